// File: rtl/timer_ctrl.sv
// Control stage ahead of the BCD countdown counter: preset selection, load/run
// sequencing, long/short start-button classification and done indication.
module timer_ctrl #(
    parameter int unsigned LONG_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       pb_mode,
    input  logic       pb_start,
    input  logic       cnt_zero,
    output logic [3:0] preset0,
    output logic [3:0] preset1,
    output logic [3:0] preset2,
    output logic [3:0] preset3,
    output logic       load,
    output logic       run,
    output logic       led_done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [3:0] LONG_LIM = 4'(LONG_TICKS);

    function automatic logic [15:0] preset_of(input logic [1:0] sel);
        logic [15:0] digits;
        case (sel)
            2'd0:    digits = 16'h0015;
            2'd1:    digits = 16'h0030;
            2'd2:    digits = 16'h0100;
            2'd3:    digits = 16'h0500;
            default: digits = 16'h0030;
        endcase
        return digits;
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_sel;
    logic [1:0]  w_sel_next;
    logic [15:0] r_preset;
    logic        r_load;
    logic        w_load_next;
    logic        r_run;
    logic        r_led_done;
    logic        r_boot;
    logic [3:0]  r_hold_cnt;
    logic [3:0]  w_hold_next;
    logic        r_long_fired;
    logic        w_long_fired_next;
    logic        r_pb_start_d;
    logic        w_fall;
    logic        w_long_ev;
    logic        w_short_ev;

    // Press classification: hold counter, long/short events and long-fired latch
    always_comb begin
        w_hold_next       = r_hold_cnt;
        w_long_fired_next = r_long_fired;
        w_fall            = r_pb_start_d & ~pb_start;
        w_long_ev         = 1'b0;
        w_short_ev        = w_fall & ~r_long_fired;
        if (!pb_start) begin
            w_hold_next = 4'd0;
        end else if (tick && (r_hold_cnt < LONG_LIM)) begin
            w_hold_next = r_hold_cnt + 4'd1;
        end else begin
            w_hold_next = r_hold_cnt;
        end
        // the tick that brings the count up to the limit is the long event itself
        if (pb_start && tick && !r_long_fired && (r_hold_cnt < LONG_LIM)
                && ((r_hold_cnt + 4'd1) == LONG_LIM)) begin
            w_long_ev         = 1'b1;
            w_long_fired_next = 1'b1;
        end else if (w_fall) begin
            w_long_fired_next = 1'b0;
        end else begin
            w_long_fired_next = r_long_fired;
        end
    end

    // Next-state, preset selection and load request
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_load_next  = r_boot;
        if (w_long_ev) begin
            w_state_next = S_IDLE;
            w_load_next  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_short_ev) begin
                        w_state_next = S_RUN;
                    end else if (pb_mode) begin
                        w_sel_next  = r_sel + 2'd1;
                        w_load_next = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt_zero) begin
                        w_state_next = S_DONE;
                    end else if (w_short_ev) begin
                        w_state_next = S_PAUSE;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (w_short_ev) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_state_next = S_PAUSE;
                    end
                end
                S_DONE: begin
                    if (w_short_ev) begin
                        w_state_next = S_IDLE;
                        w_load_next  = 1'b1;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_load_next  = 1'b1;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered outputs and press-tracking state; preset follows the new sel so it lands with load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel        <= 2'd1;
            r_preset     <= 16'h0030;
            r_load       <= 1'b0;
            r_run        <= 1'b0;
            r_led_done   <= 1'b0;
            r_boot       <= 1'b1;
            r_hold_cnt   <= 4'd0;
            r_long_fired <= 1'b0;
            r_pb_start_d <= 1'b0;
        end else begin
            r_sel        <= w_sel_next;
            r_preset     <= preset_of(w_sel_next);
            r_load       <= w_load_next;
            r_run        <= (w_state_next == S_RUN);
            r_led_done   <= (w_state_next == S_DONE);
            r_boot       <= 1'b0;
            r_hold_cnt   <= w_hold_next;
            r_long_fired <= w_long_fired_next;
            r_pb_start_d <= pb_start;
        end
    end

    assign preset0  = r_preset[15:12];
    assign preset1  = r_preset[11:8];
    assign preset2  = r_preset[7:4];
    assign preset3  = r_preset[3:0];
    assign load     = r_load;
    assign run      = r_run;
    assign led_done = r_led_done;
    assign state    = r_state;

endmodule
